link_control: RTL and testbench

Top-level sequencing FSM for the player character. Issues the one-hot phase strobes (`init`, `idle`, `reg_action`, `apply_action`, `draw_map`, `draw_char`) that the character datapath and map renderer consume, and waits on their `*_done` handshakes. Paced by a per-frame tick from the VGA timing block, so the character moves once every `MOVE_DIV` frames. Sits between the input decoder/collision checker and the character and map draw blocks.

---
 rtl/link_pkg.sv | 42 ++++
 rtl/done_watchdog.sv | 29 ++
 rtl/link_control.sv | 120 ++++++++++++
 tb/tb_link_control.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared definitions for the player-character control path: action and facing
// codes, the sequencer state encoding and a move-classification helper.
package link_pkg;

  typedef enum logic [2:0] {
    ACT_NONE   = 3'b000,
    ACT_ATTACK = 3'b001,
    ACT_UP     = 3'b010,
    ACT_DOWN   = 3'b011,
    ACT_LEFT   = 3'b100,
    ACT_RIGHT  = 3'b101
  } action_t;

  typedef enum logic [1:0] {
    F_UP    = 2'b00,
    F_DOWN  = 2'b01,
    F_LEFT  = 2'b10,
    F_RIGHT = 2'b11
  } facing_t;

  typedef enum logic [2:0] {
    ST_RST,
    ST_INIT,
    ST_IDLE,
    ST_REG,
    ST_CHECK,
    ST_APPLY,
    ST_DMAP,
    ST_DCHAR
  } state_t;

  localparam int DIV_W     = 4;
  localparam int WDOG_W    = 16;
  localparam int OVERRUN_W = 8;

  // Only directional moves can be blocked by the collision checker.
  function automatic logic is_move(input logic [2:0] act);
    return (act == ACT_UP) || (act == ACT_DOWN) ||
           (act == ACT_LEFT) || (act == ACT_RIGHT);
  endfunction

endpackage

// File: rtl/done_watchdog.sv
// Cycle counter guarding the draw handshakes; flags expiry on the TIMEOUT-th
// consecutive enabled cycle since the last clear.
module done_watchdog #(
  parameter int TIMEOUT = 65535
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/link_control.sv
// Frame-paced sequencer for the player character: registers and filters the
// requested action, then walks the datapath through apply and redraw phases.
module link_control
  import link_pkg::*;
#(
  parameter int MOVE_DIV = 2,
  parameter int TIMEOUT  = 65535
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic [2:0]           user_input,
  input  logic [1:0]           collision,
  input  logic                 map_done,
  input  logic                 char_done,
  output logic                 init,
  output logic                 idle,
  output logic                 reg_action,
  output logic                 apply_action,
  output logic                 draw_map,
  output logic                 draw_char,
  output logic [2:0]           action_out,
  output logic [OVERRUN_W-1:0] overrun,
  output logic                 timeout_err
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MOVE_DIV - 1);

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] div_cnt;
  logic             pending;
  logic             tick_avail;
  logic             waiting;
  logic             wdog_clear;
  logic             wdog_expired;
  logic             wdog_abort;

  assign tick_avail = frame_tick || pending;
  assign waiting    = (state == ST_DMAP) || (state == ST_DCHAR);
  assign wdog_clear = !waiting || (state_next != state);
  assign wdog_abort = wdog_expired &&
                      (((state == ST_DMAP) && !map_done) ||
                       ((state == ST_DCHAR) && !char_done));

  done_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (wdog_clear),
    .enable (waiting),
    .expired(wdog_expired)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_RST:   state_next = ST_INIT;
      ST_INIT:  state_next = ST_IDLE;
      ST_IDLE:  if (tick_avail && (div_cnt == DIV_LAST)) state_next = ST_REG;
      ST_REG:   state_next = ST_CHECK;
      ST_CHECK: state_next = ST_APPLY;
      ST_APPLY: state_next = ST_DMAP;
      ST_DMAP: begin
        // A done arriving on the expiry cycle still counts as success.
        if (map_done)          state_next = ST_DCHAR;
        else if (wdog_expired) state_next = ST_IDLE;
      end
      ST_DCHAR: begin
        if (char_done || wdog_expired) state_next = ST_IDLE;
      end
      default:  state_next = ST_RST;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_RST;
      div_cnt     <= '0;
      pending     <= 1'b0;
      action_out  <= ACT_NONE;
      overrun     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_next;

      // In IDLE a pending tick is consumed first; a coincident fresh tick stays owed.
      if (state == ST_IDLE) begin
        if (tick_avail) begin
          div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
        pending <= pending && frame_tick;
      end else if (frame_tick) begin
        if (pending && (overrun != '1)) begin
          overrun <= overrun + 1'b1;
        end
        pending <= 1'b1;
      end

      if (state == ST_REG) begin
        action_out <= user_input;
      end else if ((state == ST_CHECK) && (collision != 2'b00) && is_move(action_out)) begin
        action_out <= ACT_NONE;
      end

      if (wdog_abort) begin
        timeout_err <= 1'b1;
      end
    end
  end

  assign init         = (state == ST_INIT);
  assign idle         = (state == ST_IDLE);
  assign reg_action   = (state == ST_REG);
  assign apply_action = (state == ST_APPLY);
  assign draw_map     = (state == ST_DMAP);
  assign draw_char    = (state == ST_DCHAR);

endmodule

// File: tb/tb_link_control.sv
// Self-checking bench for link_control: table-driven action filtering, a
// transaction-level tick/overrun/timeout model for random rounds, and corner cases.
module tb_link_control;

  localparam int MOVE_DIV = 2;
  localparam int TIMEOUT  = 16;

  localparam logic [5:0] S_NONE  = 6'b000000;
  localparam logic [5:0] S_INIT  = 6'b100000;
  localparam logic [5:0] S_IDLE  = 6'b010000;
  localparam logic [5:0] S_REG   = 6'b001000;
  localparam logic [5:0] S_APPLY = 6'b000100;
  localparam logic [5:0] S_DMAP  = 6'b000010;
  localparam logic [5:0] S_DCHAR = 6'b000001;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [2:0] user_input = 3'b000;
  logic [1:0] collision = 2'b00;
  logic       map_done = 1'b0;
  logic       char_done = 1'b0;
  logic       init, idle, reg_action, apply_action, draw_map, draw_char;
  logic [2:0] action_out;
  logic [7:0] overrun;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  // Reference model: ticks credited toward the next move, one-deep pending
  // tick, lost-tick count and the sticky abort flag.
  int m_div  = 0;
  bit m_pend = 1'b0;
  int m_over = 0;
  bit m_terr = 1'b0;

  typedef struct {
    logic [2:0] ui;
    logic [1:0] coll;
    logic [2:0] exp_act;
  } vec_t;

  vec_t vecs [10];

  link_control #(
    .MOVE_DIV(MOVE_DIV),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .user_input  (user_input),
    .collision   (collision),
    .map_done    (map_done),
    .char_done   (char_done),
    .init        (init),
    .idle        (idle),
    .reg_action  (reg_action),
    .apply_action(apply_action),
    .draw_map    (draw_map),
    .draw_char   (draw_char),
    .action_out  (action_out),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("[TB] FAIL global_time_limit: got running expected finished");
    $fatal(1, "[TB] time limit");
  end

  function automatic logic [2:0] filt(input logic [2:0] act, input logic [1:0] coll);
    if (coll != 2'b00 && act >= 3'd2 && act <= 3'd5) return 3'b000;
    return act;
  endfunction

  task automatic check_val(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_strobes(input string name, input logic [5:0] expected);
    logic [5:0] got;
    got = {init, idle, reg_action, apply_action, draw_map, draw_char};
    checks++;
    if (got !== expected) begin
      errors++;
      $display("[TB] FAIL %s: strobes got %b expected %b", name, got, expected);
    end
  endtask

  // One clock with the given single-cycle inputs; sampling happens #1 after the edge.
  task automatic step(input bit tk, input bit md, input bit cd);
    frame_tick = tk;
    map_done   = md;
    char_done  = cd;
    @(posedge clock);
    #1;
    frame_tick = 1'b0;
    map_done   = 1'b0;
    char_done  = 1'b0;
  endtask

  task automatic lost_tick();
    if (m_pend) m_over = (m_over < 255) ? m_over + 1 : 255;
    else m_pend = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    check_strobes("reset_strobes", S_NONE);
    check_val("reset_overrun", overrun, 0);
    check_val("reset_timeout_err", timeout_err, 0);
    check_val("reset_action", action_out, 0);
    reset = 1'b0;
    step(0, 0, 0);
    check_strobes("release_init", S_INIT);
    step(0, 0, 0);
    check_strobes("release_idle", S_IDLE);
    m_div = 0; m_pend = 1'b0; m_over = 0; m_terr = 1'b0;
  endtask

  // One full move from IDLE back to IDLE. map_delay/char_delay give the wait-state
  // cycle (1-based) carrying the done pulse; 0 or >TIMEOUT means it never comes.
  // tick_mode: 0 no busy ticks, 1 random busy ticks and stray dones, 2 ticks on DMAP cycles 1..3.
  task automatic run_round(input logic [2:0] ui, input logic [1:0] coll,
                           input logic [2:0] exp_act, input int map_delay,
                           input int char_delay, input int tick_mode);
    bit tk, go_char;
    int c;
    user_input = ui;
    collision  = coll;
    while (1) begin
      if (m_pend) begin
        m_pend = 1'b0;
        step(0, 0, 0);
      end else begin
        if (tick_mode == 1 && $urandom_range(0, 2) == 0) begin
          step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          check_strobes("idle_gap", S_IDLE);
        end
        step(1, 0, 0);
      end
      m_div++;
      if (m_div == MOVE_DIV) begin
        m_div = 0;
        check_strobes("reg", S_REG);
        break;
      end
      check_strobes("idle_wait", S_IDLE);
    end
    for (int k = 0; k < 3; k++) begin
      tk = (tick_mode == 1) && ($urandom_range(0, 3) == 0);
      step(tk, 0, 0);
      if (tk) lost_tick();
      if (k == 0) check_strobes("check_phase", S_NONE);
      if (k == 1) begin
        check_strobes("apply", S_APPLY);
        check_val("apply_action_out", action_out, exp_act);
      end
    end
    go_char = 1'b0;
    c = 1;
    while (1) begin
      check_strobes("dmap", S_DMAP);
      tk = (tick_mode == 1) ? ($urandom_range(0, 3) == 0) : ((tick_mode == 2) && c <= 3);
      step(tk, (c == map_delay), (tick_mode == 1) && ($urandom_range(0, 3) == 0));
      if (tk) lost_tick();
      if (c == map_delay) begin go_char = 1'b1; break; end
      if (c == TIMEOUT) begin m_terr = 1'b1; break; end
      c++;
    end
    if (go_char) begin
      c = 1;
      while (1) begin
        check_strobes("dchar", S_DCHAR);
        tk = (tick_mode == 1) && ($urandom_range(0, 3) == 0);
        step(tk, (tick_mode == 1) && ($urandom_range(0, 3) == 0), (c == char_delay));
        if (tk) lost_tick();
        if (c == char_delay) break;
        if (c == TIMEOUT) begin m_terr = 1'b1; break; end
        c++;
      end
    end
    check_strobes("back_to_idle", S_IDLE);
    check_val("round_action_out", action_out, exp_act);
    check_val("round_overrun", overrun, m_over);
    check_val("round_timeout_err", timeout_err, m_terr);
  endtask

  initial begin
    logic [2:0] ui;
    logic [1:0] co;

    vecs[0] = '{3'b100, 2'b00, 3'b100};
    vecs[1] = '{3'b010, 2'b01, 3'b000};
    vecs[2] = '{3'b001, 2'b11, 3'b001};
    vecs[3] = '{3'b000, 2'b10, 3'b000};
    vecs[4] = '{3'b101, 2'b00, 3'b101};
    vecs[5] = '{3'b011, 2'b10, 3'b000};
    vecs[6] = '{3'b100, 2'b11, 3'b000};
    vecs[7] = '{3'b101, 2'b01, 3'b000};
    vecs[8] = '{3'b010, 2'b00, 3'b010};
    vecs[9] = '{3'b011, 2'b00, 3'b011};

    $display("[TB] reset and release");
    do_reset();

    $display("[TB] action filter table");
    foreach (vecs[i]) run_round(vecs[i].ui, vecs[i].coll, vecs[i].exp_act, 2, 2, 0);

    $display("[TB] three ticks during map draw");
    run_round(3'b100, 2'b00, 3'b100, 6, 3, 2);
    check_val("overrun_three_ticks", overrun, 2);
    run_round(3'b001, 2'b00, 3'b001, 1, 1, 0);

    $display("[TB] map draw watchdog");
    run_round(3'b101, 2'b00, 3'b101, 0, 2, 0);
    check_val("timeout_err_set", timeout_err, 1);
    check_strobes("timeout_idle", S_IDLE);

    $display("[TB] reset during character draw");
    do_reset();
    step(1, 0, 0);
    check_strobes("seq_idle", S_IDLE);
    step(1, 0, 0);
    check_strobes("seq_reg", S_REG);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check_strobes("seq_dmap", S_DMAP);
    step(0, 1, 0);
    check_strobes("seq_dchar", S_DCHAR);
    reset = 1'b1;
    step(0, 0, 0);
    check_strobes("reset_in_dchar", S_NONE);
    reset = 1'b0;
    step(0, 0, 0);
    check_strobes("reinit", S_INIT);
    step(0, 0, 0);
    check_strobes("reidle", S_IDLE);
    m_div = 0; m_pend = 1'b0; m_over = 0; m_terr = 1'b0;

    $display("[TB] random rounds");
    for (int r = 0; r < 40; r++) begin
      ui = 3'($urandom_range(0, 5));
      co = 2'($urandom_range(0, 3));
      run_round(ui, co, filt(ui, co), $urandom_range(0, 18), $urandom_range(0, 18), 1);
    end

    $display("[TB] overrun saturation");
    do_reset();
    for (int k = 0; k < 400; k++) step(1, 0, 0);
    check_val("overrun_saturated", overrun, 255);
    check_val("sat_timeout_err", timeout_err, 1);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
